muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide execution unit, a neighbouring stage of the register file.
//  - Upstream: consumes the register file's two read-data outputs as operands.
//  - Downstream: drives that file's write port (data/addr/enable) for rd.
//  - Adds the M extension without a combinational 32x32 multiplier; stalls the pipeline via busy.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk          in   1     clock, all state updates on posedge
//  reset        in   1     synchronous, active-high; one clock, sampled on posedge clk
//  start        in   1     request pulse; accepted only in IDLE
//  funct3       in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1_data     in   XLEN  operand A (register file read_data1)
//  rs2_data     in   XLEN  operand B (register file read_data2)
//  rd_addr      in   5     destination register
//  busy         out  1     high whenever state != IDLE
//  done         out  1     one-cycle pulse, result valid
//  result       out  XLEN  final value; held stable until next accepted start
//  wb_addr      out  5     rd captured at start
//  wb_en        out  1     = done && (wb_addr != 0)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, wb_en=0, result=0, wb_addr=0, counter=0.
//  - Reset mid-operation: abort immediately, no done or wb_en, return to the reset values above.
//  - FSM: IDLE -> BUSY -> DONE -> IDLE.
//    - IDLE: on start, latch funct3, rd_addr, |A|, |B| and operand signs; counter=0; go to BUSY.
//    - BUSY: one bit per cycle, counter++; after XLEN iterations (counter==XLEN-1) go to DONE.
//    - DONE: sign-corrected result registered; done=1 for exactly this cycle; next state IDLE.
//  - Latency: start high in cycle 0 -> done high in cycle XLEN+1 (33). Fixed for all ops,
//    including the special cases below.
//  - Throughput: the next start is accepted in cycle XLEN+2 at the earliest.
//  - start while busy (BUSY or DONE) is ignored; the operation is not queued.
//  - Operand capture: only on the start cycle. Later changes to rs1_data, rs2_data or rd_addr have no effect.
//  - Signedness:
//    - MUL/MULH/DIV/REM: both operands signed.
//    - MULHSU: A signed, B unsigned.
//    - MULHU/DIVU/REMU: both operands unsigned.
//  - Multiply: shift-add on magnitudes into a 2*XLEN product; negate if signs differ.
//    MUL returns the low XLEN bits, MULH* the high XLEN bits.
//  - Divide: restoring division on magnitudes.
//    - Quotient is negated if the signs differ.
//    - Remainder takes the sign of the dividend.
//  - Divide by zero (B==0): DIV/DIVU -> all ones; REM/REMU -> A unchanged.
//  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0.
//  - All arithmetic is modulo 2^XLEN; magnitude of 0x80000000 = 0x80000000 (unsigned).
//  - rd_addr==0: the operation runs normally, done pulses, wb_en stays 0.
// STRUCTURE
//  - Shared package riscv_m_pkg holds:
//    - funct3 localparams (F3_MUL..F3_REMU)
//    - state encoding (ST_IDLE, ST_BUSY, ST_DONE)
//    - DIV_BY_ZERO_Q constant (all ones)
//  - Single module, no sub-module: FSM, counter, and a shared accumulator/shift register
//    (2*XLEN+1 bits) reused by both the multiply and divide paths.
// TESTING
//  1. MUL 7*(-3): A=7, B=0xFFFFFFFD, start@0 -> done@33, result=0xFFFFFFEB, wb_en=1.
//  2. MULH/MULHU/MULHSU with A=B=0xFFFFFFFF -> 0x00000000 / 0xFFFFFFFE / 0xFFFFFFFF.
//  3. DIV -20/6 -> 0xFFFFFFFD; REM -20/6 -> 0xFFFFFFFE; DIVU 20/6 -> 3; REMU 20/6 -> 2.
//  4. Special cases:
//     - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
//     - DIV 0x80000000/-1 -> 0x80000000; REM of the same operands -> 0.
//  5. Control behaviour:
//     - start pulsed again at cycle 10 with different operands -> ignored; first result unchanged at cycle 33.
//     - rd_addr=0 -> done=1 and wb_en=0.
//  6. reset=1 at cycle 15 of a DIV -> busy=0 and done=0 next cycle, no done pulse;
//     a new MULHU started after reset completes correctly in 33 cycles.

Source files
------------

// File: rtl/riscv_m_pkg.sv
// riscv_m_pkg: shared RV32M encodings and FSM states for the multiply/divide unit
package riscv_m_pkg;
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;
   localparam logic [31:0] DIV_BY_ZERO_Q = '1;
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle on magnitudes
// with a single shared 2*XLEN+1 shift register for both paths.
module muldiv_unit
   import riscv_m_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_addr,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      wb_addr,
   output logic            wb_en
);
   localparam int CW = $clog2(XLEN);
   state_t state, state_nx;
   logic [2:0] op;
   logic [XLEN-1:0] mag_b, mag_a_in, mag_b_in, quo, rem, fin;
   logic neg_res, neg_rem, b_zero, sa, sb, last, div_ok;
   logic [CW-1:0] counter;
   logic [2*XLEN:0] acc, acc_nx;
   logic [XLEN:0] mul_sum, div_hi, div_trial;
   logic [2*XLEN-1:0] prod_s;
   always_comb begin
      sa = (funct3[2] ? !funct3[0] : funct3[1:0] != 2'b11) && rs1_data[XLEN-1];
      sb = (funct3[2] ? !funct3[0] : !funct3[1]) && rs2_data[XLEN-1];
      mag_a_in = sa ? -rs1_data : rs1_data;
      mag_b_in = sb ? -rs2_data : rs2_data;
      last = counter == CW'(XLEN-1);
      mul_sum = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, mag_b} : '0);
      div_hi = acc[2*XLEN-1:XLEN-1];
      div_ok = div_hi >= {1'b0, mag_b};
      div_trial = div_hi - {1'b0, mag_b};
      acc_nx = op[2] ? {div_ok ? div_trial : div_hi, acc[XLEN-2:0], div_ok}
                     : {1'b0, mul_sum, acc[XLEN-1:1]};
      // Sign fix-up is applied to the value the final iteration produces.
      prod_s = neg_res ? -acc_nx[2*XLEN-1:0] : acc_nx[2*XLEN-1:0];
      quo = b_zero ? DIV_BY_ZERO_Q : (neg_res ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0]);
      rem = neg_rem ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
      fin = op[2] ? (op[1] ? rem : quo)
                  : (op[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
      state_nx = state == ST_IDLE ? (start ? ST_BUSY : ST_IDLE)
               : state == ST_BUSY ? (last ? ST_DONE : ST_BUSY) : ST_IDLE;
   end
   always_ff @(posedge clk) state <= reset ? ST_IDLE : state_nx;
   always_ff @(posedge clk) begin
      if (reset) begin
         op <= '0;
         wb_addr <= '0;
         mag_b <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         b_zero <= 1'b0;
         counter <= '0;
         acc <= '0;
         result <= '0;
      end else if (state == ST_IDLE && start) begin
         op <= funct3;
         wb_addr <= rd_addr;
         mag_b <= mag_b_in;
         neg_res <= sa ^ sb;
         neg_rem <= sa;
         b_zero <= rs2_data == '0;
         counter <= '0;
         acc <= {{(XLEN+1){1'b0}}, mag_a_in};
      end else if (state == ST_BUSY) begin
         acc <= acc_nx;
         counter <= counter + CW'(1);
         if (last) result <= fin;
      end
   end
   assign busy = state != ST_IDLE;
   assign done = state == ST_DONE;
   assign wb_en = done && wb_addr != '0;
endmodule
